// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types for the memory arbiter slice.
//   mem_ctrl_op_e   : level-request operation used by every memory requester
//   mem_arb_state_e : arbiter FSM states
//   mem_arb_grant_e : identifies which requester owns the backend
//   MEM_ARB_TIMEOUT_DEFAULT : default backend watchdog limit
//   is_mem_request  : true for the two encodings that start a transfer
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_ctrl_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } mem_arb_state_e;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_DBG = 1'b1
  } mem_arb_grant_e;

  localparam int MEM_ARB_TIMEOUT_DEFAULT = 255;

  // The spare encoding (2'd3) is deliberately not a request.
  function automatic logic is_mem_request(input mem_ctrl_op_e op);
    return (op == MEM_READ) || (op == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog
// Counts backend transfer cycles and flags when the limit is reached.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-low reset
//   clear  : zero the counter (asserted on the grant that starts a transfer)
//   enable : count this cycle (asserted while the transfer is in flight)
//   expire : combinational, high during the LIMIT-th enabled cycle
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT = MEM_ARB_TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Count starts at 0 in the first enabled cycle, so LIMIT-1 marks the
  // LIMIT-th cycle of the transfer.
  assign expire = enable && (count_reg == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory backend port between the CPU controller and the
// debug/loader port. Transfers are serialised; ties alternate round-robin
// with the CPU winning the first tie after reset. dbg_lock keeps the CPU
// off the backend.
// Ports:
//   clock, reset            : system clock, synchronous active-low reset
//   cpu_op/addr/wdata       : CPU request (held until cpu_done)
//   cpu_rdata, cpu_done     : CPU read data (registered), completion pulse
//   dbg_op/addr/wdata       : debug request (held until dbg_done)
//   dbg_rdata, dbg_done     : debug read data (registered), completion pulse
//   dbg_lock                : 1 = CPU is never granted
//   mem_req/we/addr/wdata   : backend request, held until mem_ack
//   mem_rdata, mem_ack      : backend read data, one-cycle completion
//   grant_dbg               : high while the debug port owns the backend
//   timeout                 : watchdog expiry pulse (coincides with done)
// Build option: define MEM_ARB_TIMEOUT_EN to enable the backend watchdog
// (TIMEOUT_CYCLES); otherwise transfers wait forever and timeout stays 0.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  mem_ctrl_op_e          cpu_op,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_done,
  input  mem_ctrl_op_e          dbg_op,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_done,
  input  logic                  dbg_lock,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  grant_dbg,
  output logic                  timeout
);

  mem_arb_state_e          state_reg;
  mem_arb_grant_e          rr_last_reg;
  mem_arb_grant_e          grant_reg;
  logic                    grant_dbg_reg;
  logic                    mem_req_reg;
  logic                    mem_we_reg;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg;
  logic [DATA_WIDTH-1:0]   mem_wdata_reg;
  logic                    timeout_reg;

  logic                    cpu_eligible;
  logic                    dbg_request;
  logic                    grant_valid;
  mem_arb_grant_e          grant_next;
  mem_ctrl_op_e            sel_op;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    expire;
  logic                    xfer_end;
  logic [DATA_WIDTH-1:0]   xfer_rdata;
  logic [1:0]              owner_onehot;

  assign cpu_eligible = is_mem_request(cpu_op) && !dbg_lock;
  assign dbg_request  = is_mem_request(dbg_op);

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_valid = 1'b0;
    grant_next  = GRANT_CPU;
    if (cpu_eligible && dbg_request) begin
      grant_valid = 1'b1;
      grant_next  = (rr_last_reg == GRANT_CPU) ? GRANT_DBG : GRANT_CPU;
    end else if (cpu_eligible) begin
      grant_valid = 1'b1;
      grant_next  = GRANT_CPU;
    end else if (dbg_request) begin
      grant_valid = 1'b1;
      grant_next  = GRANT_DBG;
    end
  end

  assign sel_op    = (grant_next == GRANT_DBG) ? dbg_op    : cpu_op;
  assign sel_addr  = (grant_next == GRANT_DBG) ? dbg_addr  : cpu_addr;
  assign sel_wdata = (grant_next == GRANT_DBG) ? dbg_wdata : cpu_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  ((state_reg == IDLE) && grant_valid),
    .enable (state_reg == XFER),
    .expire (expire)
  );
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign expire = 1'b0;
`endif

  // An ack on the expiry cycle takes priority, so a timed-out read only
  // returns all-ones when no ack arrived.
  assign xfer_end   = (state_reg == XFER) && (mem_ack || expire);
  assign xfer_rdata = mem_ack ? mem_rdata : '1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      rr_last_reg   <= GRANT_DBG;
      grant_reg     <= GRANT_CPU;
      grant_dbg_reg <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            state_reg     <= XFER;
            rr_last_reg   <= grant_next;
            grant_reg     <= grant_next;
            grant_dbg_reg <= (grant_next == GRANT_DBG);
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= (sel_op == MEM_WRITE);
            mem_addr_reg  <= sel_addr;
            mem_wdata_reg <= sel_wdata;
          end
        end
        XFER: begin
          if (xfer_end) begin
            state_reg   <= DONE;
            mem_req_reg <= 1'b0;
            timeout_reg <= !mem_ack;
          end
        end
        DONE: begin
          // The requester still holds its op here; no arbitration so it
          // is not re-issued.
          state_reg     <= IDLE;
          grant_dbg_reg <= 1'b0;
        end
        default: begin
          state_reg   <= IDLE;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  // Per-requester completion pulse and read-data register; index 0 is the
  // CPU, index 1 the debug port.
  assign owner_onehot = {grant_reg == GRANT_DBG, grant_reg == GRANT_CPU};

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  done_reg;

    always_ff @(posedge clock) begin
      if (!reset) begin
        rdata_reg <= '0;
        done_reg  <= 1'b0;
      end else begin
        done_reg <= xfer_end && owner_onehot[gi];
        if (xfer_end && owner_onehot[gi] && !mem_we_reg) begin
          rdata_reg <= xfer_rdata;
        end
      end
    end
  end

  assign cpu_rdata = g_req[0].rdata_reg;
  assign cpu_done  = g_req[0].done_reg;
  assign dbg_rdata = g_req[1].rdata_reg;
  assign dbg_done  = g_req[1].done_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign grant_dbg = grant_dbg_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives both requesters and the memory backend, and compares every DUT
// output each cycle against a transaction-timestamp reference model:
// a grant decided in cycle N puts mem_req high from N+1 through the ack
// cycle A, done pulses at A+1 and the arbiter is free again at A+2.
// Build with MEM_ARB_TIMEOUT_EN to also exercise the watchdog (limit 4).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  mem_ctrl_op_e  cpu_op, dbg_op;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          cpu_done, dbg_done, dbg_lock, mem_req, mem_we, mem_ack, grant_dbg, timeout;

  always #5 clock = ~clock;

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dbg_op(dbg_op), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done), .dbg_lock(dbg_lock),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant_dbg(grant_dbg), .timeout(timeout)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_txn = 0;

  // Requester stimulus (index 0 = CPU, 1 = debug); op 3 is the spare encoding.
  logic [1:0]    req_op    [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  bit            saw_done  [2];
  bit            auto_req      = 1'b0;
  int            forced_delay  = -1;
  int            forced_rdata  = -1;

  // Reference model: one open transaction described by timestamps.
  bit            open = 1'b0;
  int            owner, rr_last, t_start, t_end;
  bit            t_we, t_to;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_rdata;
  logic [DW-1:0] exp_rdata [2];
  bit            e_req, e_gd, e_to, e_rst;
  bit            e_done [2];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_req(input logic [1:0] op);
    return (op == 2'd1) || (op == 2'd2);
  endfunction

  task automatic model_reset();
    open = 1'b0; rr_last = 1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    saw_done[0] = 1'b0; saw_done[1] = 1'b0;
  endtask

  // One clock cycle: update requesters, drive the backend, predict the
  // outputs after the edge, clock, then compare.
  task automatic tick();
    bit in_x, cpu_ok, dbg_ok;
    int d;
    bit n_done [2];
    bit n_to;
    for (int r = 0; r < 2; r++) begin
      if (saw_done[r]) begin
        req_op[r] = 2'd0; saw_done[r] = 1'b0;
      end else if (auto_req) begin
        if (req_op[r] == 2'd3) req_op[r] = 2'd0;
        else if (req_op[r] == 2'd0) begin
          if (!(open && owner == r && cyc <= t_end + 1) && $urandom_range(0, 2) == 0) begin
            req_op[r] = 2'($urandom_range(1, 3));
            req_addr[r] = 8'($urandom); req_wdata[r] = 8'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) req_op[r] = 2'd0;
      end
    end
    if (auto_req && $urandom_range(0, 31) == 0) dbg_lock = ~dbg_lock;
    cpu_op = mem_ctrl_op_e'(req_op[0]); cpu_addr = req_addr[0]; cpu_wdata = req_wdata[0];
    dbg_op = mem_ctrl_op_e'(req_op[1]); dbg_addr = req_addr[1]; dbg_wdata = req_wdata[1];

    in_x = open && cyc >= t_start && cyc <= t_end;
    if (in_x && cyc == t_end && !t_to) begin
      mem_ack = 1'b1; mem_rdata = t_rdata;
    end else begin
      mem_ack = !in_x && ($urandom_range(0, 7) == 0);
      mem_rdata = 8'($urandom);
    end

    n_done[0] = 1'b0; n_done[1] = 1'b0; n_to = 1'b0;
    e_rst = !reset;
    if (!reset) begin
      model_reset();
    end else begin
      if (in_x && cyc == t_end) begin
        if (!t_we) exp_rdata[owner] = t_to ? 8'hFF : t_rdata;
        n_done[owner] = 1'b1; n_to = t_to;
      end
      if (!open || cyc >= t_end + 2) begin
        open = 1'b0;
        cpu_ok = is_req(req_op[0]) && !dbg_lock;
        dbg_ok = is_req(req_op[1]);
        if (cpu_ok || dbg_ok) begin
          owner   = (cpu_ok && dbg_ok) ? (rr_last == 0 ? 1 : 0) : (dbg_ok ? 1 : 0);
          rr_last = owner;
          open    = 1'b1;
          t_we    = (req_op[owner] == 2'd2);
          t_addr  = req_addr[owner];
          t_wdata = req_wdata[owner];
          t_start = cyc + 1;
          d       = (forced_delay >= 0) ? forced_delay : $urandom_range(0, TO_EN ? 6 : 3);
          t_to    = TO_EN && (d >= TO);
          t_end   = t_start + (t_to ? TO - 1 : d);
          t_rdata = (forced_rdata >= 0) ? 8'(forced_rdata) : 8'($urandom);
        end
      end
    end
    e_req = open && (cyc + 1) >= t_start && (cyc + 1) <= t_end;
    e_gd  = open && owner == 1 && (cyc + 1) >= t_start && (cyc + 1) <= t_end + 1;
    e_done[0] = n_done[0]; e_done[1] = n_done[1]; e_to = n_to;

    @(posedge clock);
    #1;
    cyc++;

    check_value("mem_req", mem_req, e_req);
    if (e_req) begin
      check_value("mem_we", mem_we, t_we);
      check_value("mem_addr", mem_addr, t_addr);
      if (t_we) check_value("mem_wdata", mem_wdata, t_wdata);
    end
    if (e_rst) begin
      check_value("reset mem_we", mem_we, 0);
      check_value("reset mem_addr", mem_addr, 0);
      check_value("reset mem_wdata", mem_wdata, 0);
    end
    check_value("cpu_done", cpu_done, e_done[0]);
    check_value("dbg_done", dbg_done, e_done[1]);
    check_value("cpu_rdata", cpu_rdata, exp_rdata[0]);
    check_value("dbg_rdata", dbg_rdata, exp_rdata[1]);
    check_value("grant_dbg", grant_dbg, e_gd);
    check_value("timeout", timeout, e_to);
    if (e_done[0] || e_done[1]) begin
      n_txn++;
      $display("txn %0d cycle %0d: %s %s addr=0x%02h wdata=0x%02h rdata=0x%02h%s",
               n_txn, cyc, owner ? "dbg" : "cpu", t_we ? "write" : "read ",
               t_addr, t_wdata, exp_rdata[owner], e_to ? " (timeout)" : "");
    end
    saw_done[0] = e_done[0];
    saw_done[1] = e_done[1];
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic grants [$];
  logic prev_req;

  initial begin
    for (int r = 0; r < 2; r++) begin
      req_op[r] = 2'd0; req_addr[r] = '0; req_wdata[r] = '0; saw_done[r] = 1'b0;
    end
    dbg_lock = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    cpu_op = MEM_NOP; dbg_op = MEM_NOP;
    cpu_addr = '0; dbg_addr = '0; cpu_wdata = '0; dbg_wdata = '0;
    model_reset();

    // Reset state.
    reset = 1'b0;
    run(2);
    reset = 1'b1;

    // CPU read of 0x3C, ack in the second transfer cycle with 0xA5.
    forced_delay = 1; forced_rdata = 8'hA5;
    req_op[0] = 2'd1; req_addr[0] = 8'h3C;
    run(8);
    check_value("cpu read rdata", cpu_rdata, 8'hA5);

    // Debug write of 0x5A to 0x10 with an immediate ack.
    forced_delay = 0; forced_rdata = -1;
    req_op[1] = 2'd2; req_addr[1] = 8'h10; req_wdata[1] = 8'h5A;
    run(6);
    check_value("dbg write keeps rdata", dbg_rdata, 8'h00);

    // Simultaneous reads from reset alternate CPU, DBG, CPU.
    reset = 1'b0;
    run(1);
    reset = 1'b1;
    req_op[0] = 2'd1; req_addr[0] = 8'h21;
    req_op[1] = 2'd1; req_addr[1] = 8'h42;
    prev_req = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (mem_req && !prev_req) grants.push_back(grant_dbg);
      prev_req = mem_req;
      for (int r = 0; r < 2; r++) if (req_op[r] == 2'd0 && !saw_done[r]) req_op[r] = 2'd1;
    end
    req_op[0] = 2'd0; req_op[1] = 2'd0;
    run(6);
    check_value("alternation count", grants.size() >= 3, 1);
    if (grants.size() >= 3) begin
      check_value("grant 1", grants[0], 1'b0);
      check_value("grant 2", grants[1], 1'b1);
      check_value("grant 3", grants[2], 1'b0);
    end

    // dbg_lock holds off a pending CPU read until released.
    dbg_lock = 1'b1;
    req_op[0] = 2'd1; req_addr[0] = 8'h77;
    run(4);
    dbg_lock = 1'b0;
    run(1);
    check_value("grant after unlock", mem_req, 1'b1);
    run(6);

    // Reset in the middle of a transfer, then a tie goes to the CPU.
    forced_delay = 5;
    req_op[0] = 2'd1; req_addr[0] = 8'h55;
    run(2);
    check_value("mid-xfer mem_req", mem_req, 1'b1);
    reset = 1'b0;
    run(1);
    reset = 1'b1;
    req_op[1] = 2'd1; req_addr[1] = 8'h66;
    run(1);
    check_value("tie after reset", {mem_req, grant_dbg}, 2'b10);
    run(14);
    req_op[0] = 2'd0; req_op[1] = 2'd0;
    run(4);

`ifdef MEM_ARB_TIMEOUT_EN
    // Backend never acks a CPU read: watchdog completes it with all-ones.
    forced_delay = 9;
    req_op[0] = 2'd1; req_addr[0] = 8'h99;
    run(8);
    check_value("timeout rdata", cpu_rdata, 8'hFF);
    run(3);
`endif

    // Randomised traffic.
    forced_delay = -1; forced_rdata = -1;
    auto_req = 1'b1;
    run(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
